// File: rtl/ps2_frame_receiver.sv
// PS/2 front end: pin synchronisers, clock de-glitch filter, 11-bit frame deframer with timeout.
// Optional F0/E0 prefix folding is enabled by defining PS2_BREAK_DECODE_EN.
`timescale 1ns/1ps
module ps2_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk100MHz_i,
    input  logic       resetN_i,
    input  logic       clkIn_i,
    input  logic       dIn_i,
    output logic [7:0] scanCode_o,
    output logic       codeValid_o,
    output logic       parityErr_o,
    output logic       frameErr_o,
    output logic       busy_o,
    output logic       keyRelease_o,
    output logic       extended_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_FULL   = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   filt_q, filt_d, filt_prev_q;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [7:0]             scan_code_q, scan_code_d;
    logic                   code_valid_q, code_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   good_byte, frame_drop;
    logic                   clk_s, dat_s, fall_edge;

    assign clk_s     = clk_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign fall_edge = filt_prev_q & ~filt_q;

    // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        good_byte    = 1'b0;
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
            if (fall_edge && !dat_s) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
        end else if (fall_edge) begin
            to_cnt_d = '0;
            case (state_q)
                ST_DATA: begin
                    shreg_d   = {dat_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_s) begin
                        frame_err_d = 1'b1;
                    end else if (!(^{shreg_q, par_q})) begin
                        parity_err_d = 1'b1;
                    end else begin
                        good_byte = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            // PS/2 clock stalled mid-frame: abandon the partial byte.
            to_cnt_d    = TO_FULL;
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign frame_drop = parity_err_d | frame_err_d;

`ifdef PS2_BREAK_DECODE_EN
    logic rel_pend_q, rel_pend_d, ext_pend_q, ext_pend_d;
    logic key_rel_q, key_rel_d, ext_flag_q, ext_flag_d;

    always_comb begin
        rel_pend_d   = rel_pend_q;
        ext_pend_d   = ext_pend_q;
        key_rel_d    = key_rel_q;
        ext_flag_d   = ext_flag_q;
        code_valid_d = 1'b0;
        scan_code_d  = scan_code_q;
        if (frame_drop) begin
            rel_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end else if (good_byte) begin
            if (shreg_q == 8'hF0) begin
                rel_pend_d = 1'b1;
            end else if (shreg_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                scan_code_d  = shreg_q;
                key_rel_d    = rel_pend_q;
                ext_flag_d   = ext_pend_q;
                rel_pend_d   = 1'b0;
                ext_pend_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk100MHz_i or negedge resetN_i) begin
        if (!resetN_i) begin
            rel_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            key_rel_q  <= 1'b0;
            ext_flag_q <= 1'b0;
        end else begin
            rel_pend_q <= rel_pend_d;
            ext_pend_q <= ext_pend_d;
            key_rel_q  <= key_rel_d;
            ext_flag_q <= ext_flag_d;
        end
    end

    assign keyRelease_o = key_rel_q;
    assign extended_o   = ext_flag_q;
`else
    always_comb begin
        code_valid_d = good_byte;
        scan_code_d  = good_byte ? shreg_q : scan_code_q;
    end

    assign keyRelease_o = 1'b0;
    assign extended_o   = 1'b0;
`endif

    always_ff @(posedge clk100MHz_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            fcnt_q       <= '0;
            to_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            scan_code_q  <= '0;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], clkIn_i};
            dat_sync_q   <= {dat_sync_q[SYNC_STAGES-2:0], dIn_i};
            filt_q       <= filt_d;
            filt_prev_q  <= filt_q;
            fcnt_q       <= fcnt_d;
            to_cnt_q     <= to_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign scanCode_o  = scan_code_q;
    assign codeValid_o = code_valid_q;
    assign parityErr_o = parity_err_q;
    assign frameErr_o  = frame_err_q;
    assign busy_o      = (state_q != ST_IDLE);
endmodule
